// File: rtl/fmc_bus_slave_if.sv
// FMC multiplexed address/data bus pins as seen by the FPGA.
// The master drives the strobes and AD input side; the slave returns read data and the drive enable.
interface fmc_bus_slave_if;
    logic        ne;
    logic        noe;
    logic        nwe;
    logic        nadv;
    logic [1:0]  nbl;
    logic [15:0] ad_in;
    logic [15:0] ad_out;
    logic        ad_oe;

    modport master (
        output ne, noe, nwe, nadv, nbl, ad_in,
        input  ad_out, ad_oe
    );

    modport slave (
        input  ne, noe, nwe, nadv, nbl, ad_in,
        output ad_out, ad_oe
    );
endinterface

// File: rtl/fmc_bus_slave.sv
// STM32 FMC multiplexed-bus responder.
// Synchronizes the bus strobes and latches the address phase.
// Turns each bus cycle into a single write strobe or a single read request toward the register file.
// Read data is returned on AD through a registered drive enable.
module fmc_bus_slave #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                aclr_n,
    fmc_bus_slave_if.slave      bus,
    output logic [15:0]         addr,
    output logic                wrreq,
    output logic [15:0]         wrdata,
    output logic [1:0]          byteena,
    output logic                rdreq,
    input  logic [15:0]         rddata,
    output logic                proto_err
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAddr  = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StRwait = 3'd3;
    localparam logic [2:0] StRhold = 3'd4;
    localparam logic [2:0] StWr    = 3'd5;
    localparam logic [2:0] StDone  = 3'd6;

    // Strobe synchronizers and the matching AD/NBL sample pipeline
    logic [SYNC_STAGES-1:0]       ne_sync_q, noe_sync_q, nwe_sync_q, nadv_sync_q;
    logic [SYNC_STAGES-1:0][15:0] ad_pipe_q;
    logic [SYNC_STAGES-1:0][1:0]  nbl_pipe_q;

    logic        ne_s, noe_s, nwe_s, nadv_s;
    logic [15:0] ad_smp;
    logic [1:0]  nbl_smp;

    assign ne_s    = ne_sync_q[SYNC_STAGES-1];
    assign noe_s   = noe_sync_q[SYNC_STAGES-1];
    assign nwe_s   = nwe_sync_q[SYNC_STAGES-1];
    assign nadv_s  = nadv_sync_q[SYNC_STAGES-1];
    assign ad_smp  = ad_pipe_q[SYNC_STAGES-1];
    assign nbl_smp = nbl_pipe_q[SYNC_STAGES-1];

    // Shift strobes and bus samples through equal-depth pipelines so they stay aligned
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            ne_sync_q   <= '1;
            noe_sync_q  <= '1;
            nwe_sync_q  <= '1;
            nadv_sync_q <= '1;
            ad_pipe_q   <= '0;
            nbl_pipe_q  <= '1;
        end else begin
            ne_sync_q   <= {ne_sync_q[SYNC_STAGES-2:0], bus.ne};
            noe_sync_q  <= {noe_sync_q[SYNC_STAGES-2:0], bus.noe};
            nwe_sync_q  <= {nwe_sync_q[SYNC_STAGES-2:0], bus.nwe};
            nadv_sync_q <= {nadv_sync_q[SYNC_STAGES-2:0], bus.nadv};
            ad_pipe_q   <= {ad_pipe_q[SYNC_STAGES-2:0], bus.ad_in};
            nbl_pipe_q  <= {nbl_pipe_q[SYNC_STAGES-2:0], bus.nbl};
        end
    end

    logic [2:0]  state_q, state_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wrdata_q, wrdata_d;
    logic [1:0]  byteena_q, byteena_d;
    logic        wrreq_q, wrreq_d;
    logic        rdreq_q, rdreq_d;
    logic [15:0] ad_out_q, ad_out_d;
    logic        ad_oe_q, ad_oe_d;
    logic        proto_err_q, proto_err_d;

    // Bus-cycle FSM next-state; ne_s high aborts any access back to idle
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        addr_d      = addr_q;
        wrdata_d    = wrdata_q;
        byteena_d   = byteena_q;
        wrreq_d     = 1'b0;
        rdreq_d     = 1'b0;
        ad_out_d    = ad_out_q;
        ad_oe_d     = ad_oe_q;
        proto_err_d = proto_err_q;

        if (ne_s) begin
            state_d = StIdle;
            ad_oe_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!nadv_s) begin
                        state_d     = StAddr;
                        addr_d      = ad_smp;
                        proto_err_d = 1'b0;
                    end
                end
                StAddr: begin
                    // Keep tracking AD so addr ends on the last sample before nadv rises
                    if (!nadv_s) begin
                        addr_d = ad_smp;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    if (!noe_s && !nwe_s) begin
                        proto_err_d = 1'b1;
                        state_d     = StDone;
                    end else if (!noe_s) begin
                        rdreq_d   = 1'b1;
                        lat_cnt_d = '0;
                        state_d   = StRwait;
                    end else if (!nwe_s) begin
                        wrdata_d  = ad_smp;
                        byteena_d = ~nbl_smp;
                        state_d   = StWr;
                    end
                end
                StRwait: begin
                    // rddata becomes valid READ_LATENCY clocks after the rdreq cycle
                    if (lat_cnt_q == 3'(READ_LATENCY)) begin
                        ad_out_d = rddata;
                        ad_oe_d  = 1'b1;
                        state_d  = StRhold;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 3'd1;
                    end
                end
                StRhold: begin
                    if (noe_s) begin
                        ad_oe_d = 1'b0;
                        state_d = StDone;
                    end
                end
                StWr: begin
                    if (!nwe_s) begin
                        wrdata_d  = ad_smp;
                        byteena_d = ~nbl_smp;
                    end else begin
                        wrreq_d = 1'b1;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    // Further strobes in this ne window are ignored
                end
                default: begin
                    state_d = StIdle;
                    ad_oe_d = 1'b0;
                end
            endcase
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q     <= StIdle;
            lat_cnt_q   <= '0;
            addr_q      <= '0;
            wrdata_q    <= '0;
            byteena_q   <= '0;
            wrreq_q     <= 1'b0;
            rdreq_q     <= 1'b0;
            ad_out_q    <= '0;
            ad_oe_q     <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            addr_q      <= addr_d;
            wrdata_q    <= wrdata_d;
            byteena_q   <= byteena_d;
            wrreq_q     <= wrreq_d;
            rdreq_q     <= rdreq_d;
            ad_out_q    <= ad_out_d;
            ad_oe_q     <= ad_oe_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign addr       = addr_q;
    assign wrdata     = wrdata_q;
    assign byteena    = byteena_q;
    assign wrreq      = wrreq_q;
    assign rdreq      = rdreq_q;
    assign proto_err  = proto_err_q;
    assign bus.ad_out = ad_out_q;
    assign bus.ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_fmc_bus_slave.sv
// Self-checking bench for fmc_bus_slave: scoreboarded writes/reads plus latency and error cases.
module tb_fmc_bus_slave;

    localparam int unsigned SyncStages  = 2;
    localparam int unsigned ReadLatency = 1;

    logic        clk = 1'b0;
    logic        aclr_n;
    logic [15:0] addr, wrdata, rddata;
    logic [1:0]  byteena;
    logic        wrreq, rdreq, proto_err;

    always #5 clk = ~clk;

    fmc_bus_slave_if bus ();

    fmc_bus_slave #(
        .SYNC_STAGES  (SyncStages),
        .READ_LATENCY (ReadLatency)
    ) dut (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .bus       (bus),
        .addr      (addr),
        .wrreq     (wrreq),
        .wrdata    (wrdata),
        .byteena   (byteena),
        .rdreq     (rdreq),
        .rddata    (rddata),
        .proto_err (proto_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [15:0] rd_q[$];

    // Register file model: data only valid exactly ReadLatency clocks after rdreq
    logic [15:0] regfile [256];
    logic [15:0] rd_pipe [ReadLatency];

    always @(posedge clk) begin
        rd_pipe[0] <= rdreq ? regfile[addr[7:0]] : 16'hDEAD;
        for (int i = 1; i < int'(ReadLatency); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rddata = rd_pipe[ReadLatency-1];

    // Scoreboard monitor: every strobe must match a pending expectation
    wr_exp_t     mon_wr;
    logic [15:0] mon_rd;
    always @(negedge clk) begin
        if (wrreq || rdreq) check("strobe_excl", {31'b0, wrreq & rdreq}, 32'd0);
        if (wrreq) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                mon_wr = wr_q.pop_front();
                check("wr_addr", {16'b0, addr}, {16'b0, mon_wr.addr});
                check("wr_data", {16'b0, wrdata}, {16'b0, mon_wr.data});
                check("wr_be", {30'b0, byteena}, {30'b0, mon_wr.be});
            end
        end
        if (rdreq) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                mon_rd = rd_q.pop_front();
                check("rd_addr", {16'b0, addr}, {16'b0, mon_rd});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic addr_phase(input logic [15:0] a);
        @(negedge clk);
        bus.ne    = 1'b0;
        bus.nadv  = 1'b0;
        bus.ad_in = a;
        idle(3);
        bus.nadv  = 1'b1;
        bus.ad_in = 16'h0000;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] nbl,
                             input bit chk_perr_clear);
        int lat;
        wr_q.push_back('{addr: a, data: d, be: ~nbl});
        addr_phase(a);
        if (chk_perr_clear) check("perr_clear", {31'b0, proto_err}, 32'd0);
        bus.ad_in = d;
        bus.nbl   = nbl;
        bus.nwe   = 1'b0;
        idle(5);
        bus.nwe   = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (wrreq) begin
                lat = i;
                break;
            end
        end
        check("wr_latency", lat, SyncStages + 1);
        idle(1);
        bus.ne    = 1'b1;
        bus.nbl   = 2'b11;
        bus.ad_in = 16'h0000;
        idle(4);
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] exp);
        int lat;
        rd_q.push_back(a);
        addr_phase(a);
        bus.noe = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rdreq) begin
                lat = i;
                break;
            end
        end
        check("rd_latency", lat, SyncStages + 1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.ad_oe) begin
                lat = i;
                break;
            end
        end
        check("oe_latency", lat, ReadLatency + 1);
        idle(2);
        check("rd_ad_oe", {31'b0, bus.ad_oe}, 32'd1);
        check("rd_data", {16'b0, bus.ad_out}, {16'b0, exp});
        bus.noe = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!bus.ad_oe) begin
                lat = i;
                break;
            end
        end
        check("oe_release", {31'b0, (lat > 0 && lat <= int'(SyncStages) + 1)}, 32'd1);
        bus.ne = 1'b1;
        idle(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) regfile[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
        regfile[8'h04] = 16'hBEEF;
        regfile[8'h00] = 16'h1234;

        bus.ne    = 1'b1;
        bus.noe   = 1'b1;
        bus.nwe   = 1'b1;
        bus.nadv  = 1'b1;
        bus.nbl   = 2'b11;
        bus.ad_in = 16'h0000;
        aclr_n    = 1'b0;
        idle(3);
        check("rst_ad_oe", {31'b0, bus.ad_oe}, 32'd0);
        check("rst_ad_out", {16'b0, bus.ad_out}, 32'd0);
        check("rst_addr", {16'b0, addr}, 32'd0);
        check("rst_strobes", {30'b0, wrreq, rdreq}, 32'd0);
        check("rst_wrdata", {14'b0, byteena, wrdata}, 32'd0);
        check("rst_perr", {31'b0, proto_err}, 32'd0);
        aclr_n = 1'b1;
        idle(3);

        // Full-word and byte-lane writes
        bus_write(16'h0010, 16'hA5C3, 2'b00, 1'b0);
        bus_write(16'h0012, 16'h12FF, 2'b10, 1'b0);
        check("wrdata_hold", {16'b0, wrdata}, 32'h12FF);

        bus_read(16'h0004, 16'hBEEF);

        // Abort mid-write: ne rises while nwe still low, no wrreq expected
        addr_phase(16'h0030);
        bus.ad_in = 16'h5555;
        bus.nwe   = 1'b0;
        idle(3);
        bus.ne = 1'b1;
        idle(4);
        bus.nwe = 1'b1;
        idle(6);
        check("abort_oe", {31'b0, bus.ad_oe}, 32'd0);
        bus_read(16'h0000, 16'h1234);
        check("addr_hold", {16'b0, addr}, 32'h0000);

        // Protocol error: noe and nwe low together
        addr_phase(16'h0040);
        bus.noe = 1'b0;
        bus.nwe = 1'b0;
        idle(6);
        check("perr_set", {31'b0, proto_err}, 32'd1);
        check("perr_no_oe", {31'b0, bus.ad_oe}, 32'd0);
        bus.noe = 1'b1;
        bus.nwe = 1'b1;
        idle(2);
        bus.ne = 1'b1;
        idle(4);
        check("perr_sticky", {31'b0, proto_err}, 32'd1);
        bus_write(16'h0042, 16'h7E7E, 2'b01, 1'b1);

        // Reset while driving read data
        rd_q.push_back(16'h0004);
        addr_phase(16'h0004);
        bus.noe = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.ad_oe) begin
                lat = i;
                break;
            end
        end
        check("rst_pre_oe", {31'b0, (lat != 0)}, 32'd1);
        #2 aclr_n = 1'b0;
        #1;
        check("rst_async_oe", {31'b0, bus.ad_oe}, 32'd0);
        check("rst_async_addr", {16'b0, addr}, 32'd0);
        check("rst_async_out", {16'b0, bus.ad_out}, 32'd0);
        bus.noe  = 1'b1;
        bus.ne   = 1'b1;
        bus.nadv = 1'b1;
        idle(2);
        aclr_n = 1'b1;
        idle(4);
        bus_write(16'h0020, 16'h0001, 2'b00, 1'b0);

        idle(4);
        check("wr_q_empty", wr_q.size(), 32'd0);
        check("rd_q_empty", rd_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
